// File: rtl/sram_pkg.sv
// Shared widths, opcodes and FSM state encoding for the SRAM block engine.
package sram_pkg;

    localparam int A_WIDTH = 7;
    localparam int D_WIDTH = 32;
    localparam int L_WIDTH = 8;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_COPY_RD   = 3'd2,
        ST_COPY_WR   = 3'd3,
        ST_SUM_RD    = 3'd4,
        ST_SUM_DRAIN = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/sram_block_engine.sv
// Command-driven FILL / COPY / SUM initiator for a single-port synchronous SRAM.
// SRAM pins are decoded from registered state and the word index only.
module sram_block_engine #(
    parameter int A_WIDTH = sram_pkg::A_WIDTH,
    parameter int D_WIDTH = sram_pkg::D_WIDTH,
    parameter int L_WIDTH = sram_pkg::L_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Cmd_Valid,
    output logic               Cmd_Ready,
    input  logic [1:0]         Cmd_Op,
    input  logic [A_WIDTH-1:0] Cmd_Src,
    input  logic [A_WIDTH-1:0] Cmd_Dst,
    input  logic [L_WIDTH-1:0] Cmd_Len,
    input  logic [D_WIDTH-1:0] Cmd_Pattern,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [D_WIDTH-1:0] Result,
    output logic [A_WIDTH-1:0] Mem_Addr,
    output logic               Mem_RW,
    output logic               Mem_En,
    output logic [D_WIDTH-1:0] Mem_Wdata,
    input  logic [D_WIDTH-1:0] Mem_Rdata
);
    import sram_pkg::*;

    localparam logic [L_WIDTH-1:0] MAX_LEN = L_WIDTH'(2 ** A_WIDTH);

    state_t             state_r;
    logic [A_WIDTH-1:0] src_r;
    logic [A_WIDTH-1:0] dst_r;
    logic [L_WIDTH-1:0] len_r;
    logic [D_WIDTH-1:0] pattern_r;
    logic [L_WIDTH-1:0] idx_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic [D_WIDTH-1:0] result_r;

    logic               last_s;
    logic [A_WIDTH-1:0] idx_a_s;
    logic               mem_en_s;
    logic               mem_rw_s;
    logic [A_WIDTH-1:0] mem_addr_s;
    logic [D_WIDTH-1:0] mem_wdata_s;

    // Address offset wraps modulo the SRAM depth by truncation.
    assign idx_a_s = idx_r[A_WIDTH-1:0];
    assign last_s  = (idx_r == (len_r - L_WIDTH'(1)));

    // Sequencer: command accept, per-word stepping and status registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            pattern_r <= '0;
            idx_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            result_r  <= '0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Cmd_Valid) begin
                        src_r     <= Cmd_Src;
                        dst_r     <= Cmd_Dst;
                        len_r     <= Cmd_Len;
                        pattern_r <= Cmd_Pattern;
                        idx_r     <= '0;
                        result_r  <= '0;
                        if ((Cmd_Op == 2'b11) || (Cmd_Len > MAX_LEN)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (Cmd_Len == L_WIDTH'(0)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            busy_r <= 1'b1;
                            case (Cmd_Op)
                                OP_FILL: state_r <= ST_FILL;
                                OP_COPY: state_r <= ST_COPY_RD;
                                default: state_r <= ST_SUM_RD;
                            endcase
                        end
                    end
                end
                ST_FILL: begin
                    if (last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r <= idx_r + L_WIDTH'(1);
                    end
                end
                ST_COPY_RD: begin
                    state_r <= ST_COPY_WR;
                end
                ST_COPY_WR: begin
                    if (last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r   <= idx_r + L_WIDTH'(1);
                        state_r <= ST_COPY_RD;
                    end
                end
                ST_SUM_RD: begin
                    // Read data lags the address by one cycle; word 0 arrives at idx 1.
                    if (idx_r != L_WIDTH'(0)) begin
                        result_r <= result_r + Mem_Rdata;
                    end
                    if (last_s) begin
                        state_r <= ST_SUM_DRAIN;
                    end else begin
                        idx_r <= idx_r + L_WIDTH'(1);
                    end
                end
                ST_SUM_DRAIN: begin
                    result_r <= result_r + Mem_Rdata;
                    state_r  <= ST_DONE;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM pin decode from state and word index.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_rw_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        case (state_r)
            ST_FILL: begin
                mem_en_s    = 1'b1;
                mem_rw_s    = 1'b1;
                mem_addr_s  = dst_r + idx_a_s;
                mem_wdata_s = pattern_r;
            end
            ST_COPY_RD: begin
                mem_en_s   = 1'b1;
                mem_addr_s = src_r + idx_a_s;
            end
            ST_COPY_WR: begin
                mem_en_s    = 1'b1;
                mem_rw_s    = 1'b1;
                mem_addr_s  = dst_r + idx_a_s;
                mem_wdata_s = Mem_Rdata;
            end
            ST_SUM_RD: begin
                mem_en_s   = 1'b1;
                mem_addr_s = src_r + idx_a_s;
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    assign Cmd_Ready = (state_r == ST_IDLE) && !Rst;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Error     = error_r;
    assign Result    = result_r;
    assign Mem_En    = mem_en_s;
    assign Mem_RW    = mem_rw_s;
    assign Mem_Addr  = mem_addr_s;
    assign Mem_Wdata = mem_wdata_s;

endmodule

// File: tb/tb_sram_block_engine.sv
// Directed bench for sram_block_engine with a behavioural 128x32 synchronous SRAM.
module tb_sram_block_engine;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_src;
    logic [6:0]  cmd_dst;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_pattern;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [6:0]  mem_addr;
    logic        mem_rw;
    logic        mem_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    sram_block_engine dut (
        .Clk(clk), .Rst(rst),
        .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Op(cmd_op),
        .Cmd_Src(cmd_src), .Cmd_Dst(cmd_dst), .Cmd_Len(cmd_len), .Cmd_Pattern(cmd_pattern),
        .Busy(busy), .Done(done), .Error(error), .Result(result),
        .Mem_Addr(mem_addr), .Mem_RW(mem_rw), .Mem_En(mem_en),
        .Mem_Wdata(mem_wdata), .Mem_Rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: write commits at the edge; read data valid the following cycle, else 0.
    always @(posedge clk) begin
        if (mem_en && mem_rw) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_rw) mem_rdata <= sram[mem_addr];
        else mem_rdata <= 32'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; returns in the first cycle after accept.
    task automatic issue(input logic [1:0] op, input logic [6:0] src, input logic [6:0] dst,
                         input logic [7:0] len, input logic [31:0] pat);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
        cmd_valid = 1'b1;
        check_eq("ready_at_issue", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Waits for Done; reports the cycle it arrived at (1 = first cycle after accept).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            step();
            cyc++;
        end
        if (!done) check_eq("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic fill1(input logic [6:0] dst, input logic [31:0] val);
        int c;
        issue(2'b00, 7'd0, dst, 8'd1, val);
        wait_done(c);
        step();
    endtask

    logic [6:0]  fill_addr [0:3];
    logic [31:0] copy_val  [0:2];
    int cyc;
    int en_seen;
    int done_seen;

    initial begin
        fill_addr[0] = 7'h7E; fill_addr[1] = 7'h7F; fill_addr[2] = 7'h00; fill_addr[3] = 7'h01;
        copy_val[0] = 32'd11; copy_val[1] = 32'd22; copy_val[2] = 32'd33;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 7'd0; cmd_dst = 7'd0;
        cmd_len = 8'd0; cmd_pattern = 32'd0;
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_en", 32'(mem_en), 32'd0);
        check_eq("rst_rw", 32'(mem_rw), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

        // FILL wrapping past the top of memory
        issue(2'b00, 7'd0, 7'h7E, 8'd4, 32'hA5A5_0001);
        check_eq("fill_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_eq("fill_en", 32'(mem_en), 32'd1);
            check_eq("fill_rw", 32'(mem_rw), 32'd1);
            check_eq("fill_addr", 32'(mem_addr), 32'(fill_addr[k]));
            check_eq("fill_wdata", mem_wdata, 32'hA5A5_0001);
            step();
        end
        check_eq("fill_done", 32'(done), 32'd1);
        check_eq("fill_error", 32'(error), 32'd0);
        check_eq("fill_busy_done", 32'(busy), 32'd0);
        check_eq("fill_en_done", 32'(mem_en), 32'd0);
        step();

        // SUM of 1..4
        fill1(7'd0, 32'd1); fill1(7'd1, 32'd2); fill1(7'd2, 32'd3); fill1(7'd3, 32'd4);
        issue(2'b10, 7'd0, 7'd0, 8'd4, 32'd0);
        wait_done(cyc);
        check_eq("sum4_latency", 32'(cyc), 32'd6);
        check_eq("sum4_result", result, 32'd10);
        check_eq("sum4_error", 32'(error), 32'd0);
        step();
        check_eq("sum4_result_hold", result, 32'd10);

        // SUM carry discarded
        issue(2'b00, 7'd0, 7'd0, 8'd2, 32'hFFFF_FFFF);
        wait_done(cyc);
        step();
        issue(2'b10, 7'd0, 7'd0, 8'd2, 32'd0);
        wait_done(cyc);
        check_eq("sum_carry_latency", 32'(cyc), 32'd4);
        check_eq("sum_carry_result", result, 32'hFFFF_FFFE);
        step();

        // COPY with alternating read/write
        fill1(7'h10, 32'd11); fill1(7'h11, 32'd22); fill1(7'h12, 32'd33);
        issue(2'b01, 7'h10, 7'h40, 8'd3, 32'd0);
        for (int k = 0; k < 6; k++) begin
            check_eq("copy_en", 32'(mem_en), 32'd1);
            check_eq("copy_rw", 32'(mem_rw), 32'(k % 2));
            if (k % 2 == 0) begin
                check_eq("copy_rd_addr", 32'(mem_addr), 32'h10 + 32'(k / 2));
                check_eq("copy_rd_wdata", mem_wdata, 32'd0);
            end else begin
                check_eq("copy_wr_addr", 32'(mem_addr), 32'h40 + 32'(k / 2));
                check_eq("copy_wr_wdata", mem_wdata, copy_val[k / 2]);
            end
            step();
        end
        check_eq("copy_done", 32'(done), 32'd1);
        check_eq("copy_error", 32'(error), 32'd0);
        check_eq("copy_result", result, 32'd0);
        step();
        issue(2'b10, 7'h40, 7'd0, 8'd3, 32'd0);
        wait_done(cyc);
        check_eq("copy_sum", result, 32'd66);
        step();

        // Rejected and empty commands
        issue(2'b11, 7'd0, 7'd0, 8'd4, 32'd0);
        check_eq("op11_done", 32'(done), 32'd1);
        check_eq("op11_error", 32'(error), 32'd1);
        check_eq("op11_en", 32'(mem_en), 32'd0);
        step();
        check_eq("op11_done_pulse", 32'(done), 32'd0);
        issue(2'b00, 7'd0, 7'd0, 8'd200, 32'd0);
        check_eq("len200_done", 32'(done), 32'd1);
        check_eq("len200_error", 32'(error), 32'd1);
        check_eq("len200_en", 32'(mem_en), 32'd0);
        step();
        issue(2'b10, 7'd0, 7'd0, 8'd0, 32'd0);
        check_eq("len0_done", 32'(done), 32'd1);
        check_eq("len0_error", 32'(error), 32'd0);
        check_eq("len0_result", result, 32'd0);
        check_eq("len0_en", 32'(mem_en), 32'd0);
        step();

        // Full-depth FILL; a command offered while busy is ignored
        issue(2'b00, 7'd0, 7'h20, 8'd128, 32'h1234_5678);
        cmd_op = 2'b11; cmd_valid = 1'b1;
        repeat (3) step();
        cmd_valid = 1'b0;
        cyc = 4;
        while (!done && cyc < 400) begin
            step();
            cyc++;
        end
        check_eq("len128_latency", 32'(cyc), 32'd129);
        check_eq("len128_error", 32'(error), 32'd0);
        step();
        check_eq("busy_cmd_ignored", 32'(busy), 32'd0);

        // Reset during the second word of a COPY
        issue(2'b01, 7'd0, 7'h20, 8'd5, 32'd0);
        step(); step();
        check_eq("abort_pre_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        step();
        check_eq("abort_en", 32'(mem_en), 32'd0);
        check_eq("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
        en_seen = 0; done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            en_seen += 32'(mem_en);
            done_seen += 32'(done);
        end
        check_eq("abort_no_en", 32'(en_seen), 32'd0);
        check_eq("abort_no_done", 32'(done_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
